itrx_aib_phy_rst_seq: RTL and testbench



---
 rtl/itrx_aib_phy_rst_seq_pkg.sv | 22 ++
 rtl/itrx_aib_phy_sync_rstn.sv | 26 ++
 rtl/itrx_aib_phy_rst_seq.sv | 118 +++++++++++
 tb/tb_itrx_aib_phy_rst_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/itrx_aib_phy_rst_seq_pkg.sv
// Shared definitions for the AIB PHY reset sequencer and its CSR readback.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package itrx_aib_phy_rst_seq_pkg;

   localparam int SEQ_STATE_W = 3;

   localparam logic [SEQ_STATE_W-1:0] ST_IDLE      = 3'd0;
   localparam logic [SEQ_STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [SEQ_STATE_W-1:0] ST_RELEASE   = 3'd2;
   localparam logic [SEQ_STATE_W-1:0] ST_DONE      = 3'd3;
   localparam logic [SEQ_STATE_W-1:0] ST_HOLD      = 3'd4;

   typedef enum logic [SEQ_STATE_W-1:0] {
      S_IDLE      = ST_IDLE,
      S_WAIT_LOCK = ST_WAIT_LOCK,
      S_RELEASE   = ST_RELEASE,
      S_DONE      = ST_DONE,
      S_HOLD      = ST_HOLD
   } seq_state_e;

endpackage

// File: rtl/itrx_aib_phy_sync_rstn.sv
// Reset synchroniser: asynchronous assert, release after NDFFS clk edges; scan bypass.
// Latency: NDFFS cycles on release, zero on assertion.
// Backpressure: none.
module itrx_aib_phy_sync_rstn #(
   parameter int NDFFS = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scan_mode,
   output logic rst_n_sync
);

   logic [NDFFS-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NDFFS-2:0], 1'b1};
      end
   end

   // Scan needs the reset tree directly controllable from the pin.
   assign rst_n_sync = scan_mode ? rst_n : sync_q[NDFFS-1];

endmodule

// File: rtl/itrx_aib_phy_rst_seq.sv
// Releases NRST active-low resets in index order after PLL lock, stage_dly cycles apart.
// Latency: bit k lands (k+1)*(stage_dly+1) edges after RELEASE entry; abort lands next edge.
// Backpressure: none; loss of lock or sw_rst_req aborts into a HOLD_CYC-cycle hold.
module itrx_aib_phy_rst_seq
   import itrx_aib_phy_rst_seq_pkg::*;
#(
   parameter int NRST     = 4,
   parameter int CNTW     = 8,
   parameter int HOLD_CYC = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   scan_mode,
   input  logic                   pll_lock,
   input  logic                   sw_rst_req,
   input  logic [CNTW-1:0]        stage_dly,
   output logic [NRST-1:0]        rstn_out,
   output logic                   seq_done,
   output logic [SEQ_STATE_W-1:0] seq_state
);

   localparam int SW = (NRST > 1) ? $clog2(NRST) : 1;
   localparam logic [SW-1:0]   LAST_STAGE = SW'(NRST - 1);
   localparam logic [CNTW-1:0] HOLD_LOAD  = CNTW'(HOLD_CYC - 1);

   logic lrst_n;

   itrx_aib_phy_sync_rstn #(
      .NDFFS (2)
   ) u_sync_rstn (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_mode  (scan_mode),
      .rst_n_sync (lrst_n)
   );

   seq_state_e      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [SW-1:0]   stage_q, stage_d;
   logic [NRST-1:0] rstn_q, rstn_d;
   logic            done_q, done_d;
   logic            abort;

   assign abort = !pll_lock || sw_rst_req;

   always_ff @(posedge clk or negedge lrst_n) begin
      if (!lrst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         stage_q <= '0;
         rstn_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         rstn_q  <= rstn_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      rstn_d  = rstn_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (!abort) begin
               cnt_d   = stage_dly;
               stage_d = '0;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE, S_DONE: begin
            // Abort wins over a release landing on the same edge.
            if (abort) begin
               rstn_d  = '0;
               done_d  = 1'b0;
               cnt_d   = HOLD_LOAD;
               state_d = S_HOLD;
            end else if (state_q == S_RELEASE) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNTW'(1);
               end else begin
                  rstn_d[stage_q] = 1'b1;
                  if (stage_q == LAST_STAGE) begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     stage_d = stage_q + SW'(1);
                     cnt_d   = stage_dly;
                  end
               end
            end
         end
         S_HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNTW'(1);
            end else begin
               state_d = S_WAIT_LOCK;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rstn_out  = scan_mode ? {NRST{rst_n}} : rstn_q;
   assign seq_done  = scan_mode ? rst_n : done_q;
   assign seq_state = state_q;

endmodule

// File: tb/tb_itrx_aib_phy_rst_seq.sv
// Directed bench for the reset sequencer; expected outputs are queued per cycle and
// popped one per clock for comparison.
module tb_itrx_aib_phy_rst_seq;

   localparam int NRST = 4;
   localparam int CNTW = 8;

   logic            clk;
   logic            rst_n;
   logic            scan_mode;
   logic            pll_lock;
   logic            sw_rst_req;
   logic [CNTW-1:0] stage_dly;
   logic [NRST-1:0] rstn_out;
   logic            seq_done;
   logic [2:0]      seq_state;

   int n_chk  = 0;
   int n_pass = 0;

   logic [NRST-1:0] q_rstn[$];
   logic            q_done[$];
   logic [2:0]      q_st[$];
   string           q_tag[$];

   itrx_aib_phy_rst_seq #(
      .NRST     (NRST),
      .CNTW     (CNTW),
      .HOLD_CYC (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_mode  (scan_mode),
      .pll_lock   (pll_lock),
      .sw_rst_req (sw_rst_req),
      .stage_dly  (stage_dly),
      .rstn_out   (rstn_out),
      .seq_done   (seq_done),
      .seq_state  (seq_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [NRST-1:0] r, input logic d,
                       input logic [2:0] s);
      q_tag.push_back(tag);
      q_rstn.push_back(r);
      q_done.push_back(d);
      q_st.push_back(s);
   endtask

   function automatic logic [NRST-1:0] thermo(input int n);
      logic [NRST-1:0] v;
      v = '0;
      for (int i = 0; i < NRST; i++) if (i < n) v[i] = 1'b1;
      return v;
   endfunction

   // Edge m after the RELEASE-entry edge (m=0): bit k is up once m >= (k+1)*(dly+1).
   task automatic push_seq(input string tag, input int dly, input int m_last);
      int full;
      int n;
      full = NRST * (dly + 1);
      for (int m = 0; m <= m_last; m++) begin
         n = m / (dly + 1);
         if (n > NRST) n = NRST;
         push($sformatf("%s_m%0d", tag, m), thermo(n), (m >= full),
              (m >= full) ? 3'd3 : 3'd2);
      end
   endtask

   task automatic drain();
      string           t;
      logic [NRST-1:0] r;
      logic            d;
      logic [2:0]      s;
      while (q_rstn.size() > 0) begin
         cyc();
         t = q_tag.pop_front();
         r = q_rstn.pop_front();
         d = q_done.pop_front();
         s = q_st.pop_front();
         chk({t, "_rstn"}, 8'(rstn_out), 8'(r));
         chk({t, "_done"}, 8'(seq_done), 8'(d));
         chk({t, "_st"}, 8'(seq_state), 8'(s));
      end
   endtask

   // From DONE: one-cycle sw_rst_req pulse, 4 HOLD cycles, 1 WAIT_LOCK, then RELEASE.
   task automatic restart_from_done(input string tag);
      sw_rst_req = 1'b1;
      push({tag, "_h0"}, '0, 1'b0, 3'd4);
      drain();
      sw_rst_req = 1'b0;
      for (int i = 1; i < 4; i++) push($sformatf("%s_h%0d", tag, i), '0, 1'b0, 3'd4);
      push({tag, "_wl"}, '0, 1'b0, 3'd1);
      drain();
   endtask

   initial begin
      rst_n      = 1'b0;
      scan_mode  = 1'b0;
      pll_lock   = 1'b1;
      sw_rst_req = 1'b0;
      stage_dly  = 8'd3;
      repeat (3) cyc();

      chk("rst_rstn", 8'(rstn_out), 8'h0);
      chk("rst_done", 8'(seq_done), 8'h0);
      chk("rst_state", 8'(seq_state), 8'h0);

      // Power-up with lock already present, stage_dly=3.
      rst_n = 1'b1;
      push("pu_sync1", '0, 1'b0, 3'd0);
      push("pu_sync2", '0, 1'b0, 3'd0);
      push("pu_wl", '0, 1'b0, 3'd1);
      push_seq("pu_d3", 3, NRST * 4 + 2);
      drain();

      // sw_rst_req held 10 cycles in DONE; re-sequence with stage_dly=0.
      stage_dly  = 8'd0;
      sw_rst_req = 1'b1;
      for (int i = 0; i < 4; i++) push($sformatf("sw_hold%0d", i), '0, 1'b0, 3'd4);
      for (int i = 0; i < 6; i++) push($sformatf("sw_wl%0d", i), '0, 1'b0, 3'd1);
      drain();
      sw_rst_req = 1'b0;
      push_seq("sw_d0", 0, NRST + 1);
      drain();

      // Lock loss while rstn_out=0011, stage_dly=2.
      stage_dly = 8'd2;
      restart_from_done("ll_pre");
      push_seq("ll_pre_d2", 2, 6);
      drain();
      chk("ll_at_0011", 8'(rstn_out), 8'h3);
      pll_lock = 1'b0;
      for (int i = 0; i < 4; i++) push($sformatf("ll_hold%0d", i), '0, 1'b0, 3'd4);
      for (int i = 0; i < 3; i++) push($sformatf("ll_wl%0d", i), '0, 1'b0, 3'd1);
      drain();
      pll_lock = 1'b1;
      push_seq("ll_relock", 2, NRST * 3 + 1);
      drain();

      // Asynchronous rst_n assertion mid-RELEASE.
      restart_from_done("ar_pre");
      push_seq("ar_pre_d2", 2, 6);
      drain();
      rst_n = 1'b0;
      #1;
      chk("ar_async_rstn", 8'(rstn_out), 8'h0);
      chk("ar_async_state", 8'(seq_state), 8'h0);
      chk("ar_async_done", 8'(seq_done), 8'h0);
      push("ar_low0", '0, 1'b0, 3'd0);
      push("ar_low1", '0, 1'b0, 3'd0);
      drain();
      rst_n = 1'b1;
      push("ar_sync1", '0, 1'b0, 3'd0);
      push("ar_sync2", '0, 1'b0, 3'd0);
      push("ar_wl", '0, 1'b0, 3'd1);
      push_seq("ar_restart", 2, NRST * 3 + 1);
      drain();

      // Scan mode: outputs follow rst_n combinationally, lock irrelevant.
      scan_mode = 1'b1;
      pll_lock  = 1'b0;
      #1;
      chk("scan_hi_rstn", 8'(rstn_out), 8'hf);
      chk("scan_hi_done", 8'(seq_done), 8'h1);
      rst_n = 1'b0;
      #1;
      chk("scan_lo_rstn", 8'(rstn_out), 8'h0);
      chk("scan_lo_done", 8'(seq_done), 8'h0);
      rst_n = 1'b1;
      #1;
      chk("scan_hi2_rstn", 8'(rstn_out), 8'hf);
      chk("scan_hi2_done", 8'(seq_done), 8'h1);
      scan_mode = 1'b0;
      #1;
      chk("unscan_rstn", 8'(rstn_out), 8'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
